ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipelined MIPS processor. It consumes the ID/EX pipeline register outputs and contains the operand forwarding muxes, the single-cycle ALU, branch resolution, an iterative 32-cycle multiply/divide unit with HI/LO registers, and the EX/MEM pipeline register. Its outputs feed the data-memory stage directly. It asserts a stall toward IF/ID and ID/EX while a multiply or divide is in progress.

## Interface
Parameters:
- XLEN, 32, datapath width
- MDU_CYCLES, 32, iterations per multiply/divide

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg  in  1 each  control bits from ID/EX
- AluOp  in  6  operation code (cpu_pkg encoding)
- npc, readdata1, readdata2, sigext  in  32 each  from ID/EX
- rs, rt, rd  in  5 each  instruction fields [25:21], [20:16], [15:11]
- wb_regwrite  in  1  MEM/WB write enable
- wb_rd  in  5  MEM/WB destination register
- wb_data  in  32  MEM/WB write-back value
- stall  out  1  hold IF/ID and ID/EX
- exm_alu_result, exm_store_data, exm_branch_target  out  32 each  EX/MEM register
- exm_dest  out  5  EX/MEM destination register
- exm_pcsrc, exm_jump, exm_MemRead, exm_MemWrite, exm_RegWrite, exm_MemtoReg  out  1 each  EX/MEM register

## Operation
- Forwarding for operand A (rs) and operand B (rt) uses this priority:
  - EX/MEM if exm_RegWrite, !exm_MemRead, exm_dest!=0 and exm_dest matches.
  - Else MEM/WB if wb_regwrite, wb_rd!=0 and wb_rd matches.
  - Else readdata1/readdata2.
- Load-use hazards are resolved upstream by the decode stage.
- Operand B for the ALU is sigext when AluSrc=1. Otherwise it is the forwarded rt value.
- exm_store_data is always the forwarded rt value.
- ALU ops and their results:
  - ADD/SUB wrap modulo 2^32, with no overflow trap.
  - AND, OR, XOR, NOR are bitwise.
  - SLT is signed compare; SLTU is unsigned compare.
  - SLL/SRL/SRA shift operand B by sigext[10:6].
  - LUI gives {B[15:0],16'h0}.
  - MFHI/MFLO return HI/LO.
  - Undefined codes return 0.
- Destination register is rd when RegDst=1, else rt.
- Branch:
  - exm_branch_target = npc + (sigext<<2).
  - exm_pcsrc = branch && (A==B), where A and B are the forwarded operands.
  - jump passes through to exm_jump.
- MDU FSM states are IDLE, BUSY, DONE:
  - IDLE→BUSY when AluOp is MULT/MULTU/DIV/DIVU. Operands are captured and count=0.
  - BUSY increments count. BUSY→DONE when count==MDU_CYCLES-1.
  - DONE writes HI/LO on the exiting edge, then goes to IDLE.
- MDU datapath:
  - Multiply is shift-add on magnitudes. HI:LO holds the 64-bit product.
  - Divide is restoring division. LO=quotient, HI=remainder.
  - Signed ops: operate on magnitudes, then negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
- MDU boundary cases:
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
  - Signed 32'h80000000/-1: LO=32'h80000000, HI=0.
- stall = 1 when (state==IDLE with an MDU op in ID/EX) or state==BUSY. stall = 0 in DONE.
- While stall=1, EX/MEM loads a bubble: all control outputs 0, data fields don't-care, driven 0.
- In DONE the MDU op retires into EX/MEM with RegWrite=0.

## Timing
- Non-MDU ops have 1-cycle latency: inputs are sampled at an edge and EX/MEM is valid after that edge.
- MDU op: stall is high for 33 cycles (issue cycle plus 32 BUSY cycles), then low for the DONE cycle. HI/LO become visible to an MFHI/MFLO in the following cycle.
- On rst assertion, asynchronously and at any point, including mid-MDU operation:
  - All EX/MEM outputs go to 0.
  - HI and LO go to 0.
  - The FSM goes to IDLE with count=0, so stall=0.
  - The aborted operation is lost.
- When EX/MEM and MEM/WB both match the same register, EX/MEM wins.

## Structure
- cpu_pkg holds:
  - AluOp localparams: ADD 0x00, SUB 0x01, AND 0x02, OR 0x03, XOR 0x04, NOR 0x05, SLT 0x06, SLTU 0x07, SLL 0x08, SRL 0x09, SRA 0x0A, LUI 0x0B, MULT 0x10, MULTU 0x11, DIV 0x12, DIVU 0x13, MFHI 0x14, MFLO 0x15.
  - The MDU state enum and XLEN.
- One sub-module, mdu_iter, holds the FSM, counter, datapath and HI/LO. Forwarding, ALU and the EX/MEM register stay in ex_stage.

## Test plan
- ADD with readdata1=5, readdata2=7, RegDst=1, rd=9 → next edge: exm_alu_result=12, exm_dest=9, exm_RegWrite=1.
- Back-to-back ADD r3 then SUB using r3, with EX/MEM also writing r3=10 and MEM/WB writing r3=4 → SUB uses 10 (EX/MEM priority). Repeat with rd=0: no forwarding, readdata used.
- BEQ with npc=0x100, sigext=3 and equal forwarded operands → exm_pcsrc=1, exm_branch_target=0x10C. Unequal operands → exm_pcsrc=0.
- MULT with A=-3, B=7 → stall high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO issued next returns 0xFFFFFFEB.
- DIV of 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU of 9 by 0 → LO=0xFFFFFFFF, HI=9.
- Assert rst at BUSY count=10 → stall=0 immediately, HI=LO=0, EX/MEM controls 0. A new MULT after release completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, MDU state, datapath width.
// Imported by the execute stage and its multiply/divide unit.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [5:0] ALU_SUB   = 6'h01;
  localparam logic [5:0] ALU_AND   = 6'h02;
  localparam logic [5:0] ALU_OR    = 6'h03;
  localparam logic [5:0] ALU_XOR   = 6'h04;
  localparam logic [5:0] ALU_NOR   = 6'h05;
  localparam logic [5:0] ALU_SLT   = 6'h06;
  localparam logic [5:0] ALU_SLTU  = 6'h07;
  localparam logic [5:0] ALU_SLL   = 6'h08;
  localparam logic [5:0] ALU_SRL   = 6'h09;
  localparam logic [5:0] ALU_SRA   = 6'h0A;
  localparam logic [5:0] ALU_LUI   = 6'h0B;
  localparam logic [5:0] ALU_MULT  = 6'h10;
  localparam logic [5:0] ALU_MULTU = 6'h11;
  localparam logic [5:0] ALU_DIV   = 6'h12;
  localparam logic [5:0] ALU_DIVU  = 6'h13;
  localparam logic [5:0] ALU_MFHI  = 6'h14;
  localparam logic [5:0] ALU_MFLO  = 6'h15;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_BUSY,
    MDU_DONE
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Ports: clk, rst, op, a, b in; stall, done, hi, lo out.
module mdu_iter
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MDU_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(MDU_CYCLES);

  mdu_state_t state, state_nx;

  logic [CW-1:0]     count;
  logic [XLEN:0]     acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   dividend;
  logic              is_div_q;
  logic              neg_q;
  logic              neg_r;
  logic              div0;

  logic              start;
  logic              last;
  logic              signed_op;
  logic              is_div;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  assign start     = (state == MDU_IDLE) && is_mdu_op(op);
  assign last      = (count == CW'(MDU_CYCLES - 1));
  assign signed_op = (op == ALU_MULT) || (op == ALU_DIV);
  assign is_div    = (op == ALU_DIV) || (op == ALU_DIVU);
  assign a_neg     = signed_op & a[XLEN-1];
  assign b_neg     = signed_op & b[XLEN-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MDU_IDLE: if (start) state_nx = MDU_BUSY;
      MDU_BUSY: if (last)  state_nx = MDU_DONE;
      MDU_DONE: state_nx = MDU_IDLE;
      default:  state_nx = MDU_IDLE;
    endcase
  end

  always_comb begin
    stall = start || (state == MDU_BUSY);
    done  = (state == MDU_DONE);
  end

  // One iteration step: shift-add multiply, restoring divide.
  logic [XLEN:0] m_sum;
  logic [XLEN:0] d_try;
  logic [XLEN:0] d_sub;
  logic          d_fit;

  always_comb begin
    m_sum = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    d_try = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    d_sub = d_try - {1'b0, opnd};
    d_fit = d_try >= {1'b0, opnd};
  end

  // Sign fix-up and divide-by-zero override at retire.
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  always_comb begin
    prod   = {acc_hi[XLEN-1:0], acc_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -acc_lo : acc_lo;
    rem    = neg_r ? -acc_hi[XLEN-1:0] : acc_hi[XLEN-1:0];
    if (is_div_q) begin
      res_hi = div0 ? dividend : rem;
      res_lo = div0 ? '1 : quo;
    end else begin
      res_hi = prod_s[2*XLEN-1:XLEN];
      res_lo = prod_s[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      dividend <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (start) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= is_div ? a_mag : b_mag;
      opnd     <= is_div ? b_mag : a_mag;
      dividend <= a;
      is_div_q <= is_div;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div0     <= (b == '0);
    end else if (state == MDU_BUSY) begin
      count <= count + 1'b1;
      if (is_div_q) begin
        acc_hi <= d_fit ? d_sub : d_try;
        acc_lo <= {acc_lo[XLEN-2:0], d_fit};
      end else begin
        acc_hi <= {1'b0, m_sum[XLEN:1]};
        acc_lo <= {m_sum[0], acc_lo[XLEN-1:1]};
      end
    end else if (state == MDU_DONE) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolve, MDU, EX/MEM register.
// In: ID/EX controls/data, MEM/WB bypass. Out: stall, EX/MEM fields.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MDU_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic            jump,
  input  logic            AluSrc,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            RegDst,
  input  logic            MemtoReg,
  input  logic [5:0]      AluOp,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] readdata1,
  input  logic [XLEN-1:0] readdata2,
  input  logic [XLEN-1:0] sigext,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [XLEN-1:0] exm_alu_result,
  output logic [XLEN-1:0] exm_store_data,
  output logic [XLEN-1:0] exm_branch_target,
  output logic [4:0]      exm_dest,
  output logic            exm_pcsrc,
  output logic            exm_jump,
  output logic            exm_MemRead,
  output logic            exm_MemWrite,
  output logic            exm_RegWrite,
  output logic            exm_MemtoReg
);

  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [4:0]      shamt;
  logic            mdu_done;
  logic            exm_fwd_ok;
  logic            fa_exm, fa_wb;
  logic            fb_exm, fb_wb;

  // A load's EX/MEM value is an address, not the loaded data.
  assign exm_fwd_ok = exm_RegWrite && !exm_MemRead && (exm_dest != 5'd0);
  assign fa_exm = exm_fwd_ok && (exm_dest == rs);
  assign fb_exm = exm_fwd_ok && (exm_dest == rt);
  assign fa_wb  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs);
  assign fb_wb  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rt);

  always_comb begin
    priority case (1'b1)
      fa_exm:  opa = exm_alu_result;
      fa_wb:   opa = wb_data;
      default: opa = readdata1;
    endcase
  end

  always_comb begin
    priority case (1'b1)
      fb_exm:  opb = exm_alu_result;
      fb_wb:   opb = wb_data;
      default: opb = readdata2;
    endcase
  end

  assign alu_b = AluSrc ? sigext : opb;
  assign shamt = sigext[10:6];

  always_comb begin
    case (AluOp)
      ALU_ADD:  alu_y = opa + alu_b;
      ALU_SUB:  alu_y = opa - alu_b;
      ALU_AND:  alu_y = opa & alu_b;
      ALU_OR:   alu_y = opa | alu_b;
      ALU_XOR:  alu_y = opa ^ alu_b;
      ALU_NOR:  alu_y = ~(opa | alu_b);
      ALU_SLT:  alu_y = XLEN'($signed(opa) < $signed(alu_b));
      ALU_SLTU: alu_y = XLEN'(opa < alu_b);
      ALU_SLL:  alu_y = alu_b << shamt;
      ALU_SRL:  alu_y = alu_b >> shamt;
      ALU_SRA:  alu_y = $signed(alu_b) >>> shamt;
      ALU_LUI:  alu_y = {alu_b[15:0], 16'h0};
      ALU_MFHI: alu_y = hi;
      ALU_MFLO: alu_y = lo;
      default:  alu_y = '0;
    endcase
  end

  mdu_iter #(
    .XLEN       (XLEN),
    .MDU_CYCLES (MDU_CYCLES)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .op    (AluOp),
    .a     (opa),
    .b     (opb),
    .stall (stall),
    .done  (mdu_done),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst || stall) begin
      exm_alu_result    <= '0;
      exm_store_data    <= '0;
      exm_branch_target <= '0;
      exm_dest          <= '0;
      exm_pcsrc         <= 1'b0;
      exm_jump          <= 1'b0;
      exm_MemRead       <= 1'b0;
      exm_MemWrite      <= 1'b0;
      exm_RegWrite      <= 1'b0;
      exm_MemtoReg      <= 1'b0;
    end else begin
      exm_alu_result    <= alu_y;
      exm_store_data    <= opb;
      exm_branch_target <= npc + (sigext << 2);
      exm_dest          <= RegDst ? rd : rt;
      exm_pcsrc         <= branch && (opa == opb);
      exm_jump          <= jump;
      exm_MemRead       <= MemRead;
      exm_MemWrite      <= MemWrite;
      exm_RegWrite      <= RegWrite && !mdu_done;
      exm_MemtoReg      <= MemtoReg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with an expected-result queue.
// Covers ALU, forwarding, branch, MDU timing/results, async reset.
module tb_ex_stage;
  import cpu_pkg::*;

  logic        clk, rst;
  logic        branch, jump, AluSrc, MemRead, MemWrite;
  logic        RegWrite, RegDst, MemtoReg;
  logic [5:0]  AluOp;
  logic [31:0] npc, readdata1, readdata2, sigext;
  logic [4:0]  rs, rt, rd;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] exm_alu_result, exm_store_data, exm_branch_target;
  logic [4:0]  exm_dest;
  logic        exm_pcsrc, exm_jump, exm_MemRead, exm_MemWrite;
  logic        exm_RegWrite, exm_MemtoReg;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .branch(branch), .jump(jump), .AluSrc(AluSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .AluOp(AluOp),
    .npc(npc), .readdata1(readdata1), .readdata2(readdata2),
    .sigext(sigext), .rs(rs), .rt(rt), .rd(rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall),
    .exm_alu_result(exm_alu_result),
    .exm_store_data(exm_store_data),
    .exm_branch_target(exm_branch_target),
    .exm_dest(exm_dest), .exm_pcsrc(exm_pcsrc), .exm_jump(exm_jump),
    .exm_MemRead(exm_MemRead), .exm_MemWrite(exm_MemWrite),
    .exm_RegWrite(exm_RegWrite), .exm_MemtoReg(exm_MemtoReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        rw;
    logic        pc;
    logic [31:0] tgt;
    logic [31:0] sd;
  } exp_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sig;
    logic        src;
    logic [31:0] y;
  } alu_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_t tbl [12] = '{
    '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   1'b0, 32'hF000F000},
    '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   1'b0, 32'hFFF0FFF0},
    '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   1'b0, 32'h0FF00FF0},
    '{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   1'b0, 32'h000F000F},
    '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0,   1'b0, 32'h00000001},
    '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0,   1'b0, 32'h00000000},
    '{ALU_SLL,  32'h0,        32'h00000001, 32'h100, 1'b0, 32'h00000010},
    '{ALU_SRL,  32'h0,        32'h80000000, 32'h100, 1'b0, 32'h08000000},
    '{ALU_SRA,  32'h0,        32'h80000000, 32'h100, 1'b0, 32'hF8000000},
    '{ALU_LUI,  32'h0,        32'h00000077, 32'h1234, 1'b1, 32'h12340000},
    '{ALU_ADD,  32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h9},
    '{6'h0C,    32'h5,        32'h5,        32'h0,   1'b0, 32'h0}
  };

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    branch = 0; jump = 0; AluSrc = 0; MemRead = 0; MemWrite = 0;
    RegWrite = 0; RegDst = 0; MemtoReg = 0; AluOp = ALU_ADD;
    npc = 0; readdata1 = 0; readdata2 = 0; sigext = 0;
    rs = 0; rt = 0; rd = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic push(input logic [31:0] res, input logic [4:0] dest,
                      input logic rw, input logic pc,
                      input logic [31:0] tgt, input logic [31:0] sd);
    exp_t e;
    e.res = res; e.dest = dest; e.rw = rw;
    e.pc = pc; e.tgt = tgt; e.sd = sd;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".res"},  exm_alu_result,    e.res);
    chk({tag, ".dest"}, 32'(exm_dest),     32'(e.dest));
    chk({tag, ".rw"},   32'(exm_RegWrite), 32'(e.rw));
    chk({tag, ".pc"},   32'(exm_pcsrc),    32'(e.pc));
    chk({tag, ".tgt"},  exm_branch_target, e.tgt);
    chk({tag, ".sd"},   exm_store_data,    e.sd);
  endtask

  task automatic run_op(input string tag);
    tick();
    check_out(tag);
  endtask

  task automatic mdu_run(input string tag, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    logic [5:0] ctl;
    clr();
    AluOp = op; rs = 5'd16; rt = 5'd17; rd = 5'd19;
    RegDst = 1; RegWrite = 1;
    readdata1 = a; readdata2 = b;
    #1;
    chk({tag, ".stall_issue"}, 32'(stall), 32'd1);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      tick();
      n++;
      ctl = {exm_pcsrc, exm_jump, exm_MemRead,
             exm_MemWrite, exm_RegWrite, exm_MemtoReg};
      chk({tag, ".bubble"}, 32'(ctl), 32'd0);
    end
    chk({tag, ".stall_cycles"}, n, 33);
    tick();
    chk({tag, ".retire_rw"}, 32'(exm_RegWrite), 32'd0);
    clr();
    AluOp = ALU_MFLO; RegDst = 1; rd = 5'd18; RegWrite = 1;
    push(elo, 5'd18, 1'b1, 1'b0, 32'h0, 32'h0);
    run_op({tag, ".mflo"});
    AluOp = ALU_MFHI;
    push(ehi, 5'd18, 1'b1, 1'b0, 32'h0, 32'h0);
    run_op({tag, ".mfhi"});
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.res",   exm_alu_result, 32'd0);
    chk("rst.sd",    exm_store_data, 32'd0);
    chk("rst.tgt",   exm_branch_target, 32'd0);
    chk("rst.dest",  32'(exm_dest), 32'd0);
    chk("rst.ctl",   32'({exm_pcsrc, exm_jump, exm_MemRead, exm_MemWrite,
                          exm_RegWrite, exm_MemtoReg}), 32'd0);
    rst = 1'b0;

    // ADD 5+7 -> r9
    clr();
    rs = 1; rt = 2; rd = 9; readdata1 = 5; readdata2 = 7;
    RegDst = 1; RegWrite = 1;
    push(32'd12, 5'd9, 1'b1, 1'b0, 32'h0, 32'd7);
    run_op("add");

    // ADD r3 = 10, then SUB reads r3 with both bypasses matching
    rd = 3; readdata1 = 6; readdata2 = 4;
    push(32'd10, 5'd3, 1'b1, 1'b0, 32'h0, 32'd4);
    run_op("add_r3");
    clr();
    AluOp = ALU_SUB; rs = 3; rt = 5; rd = 7; RegDst = 1; RegWrite = 1;
    readdata1 = 99; readdata2 = 3;
    wb_regwrite = 1; wb_rd = 3; wb_data = 4;
    push(32'd7, 5'd7, 1'b1, 1'b0, 32'h0, 32'd3);
    run_op("fwd_exm_prio");

    // MEM/WB only
    AluOp = ALU_ADD; rs = 3; rt = 0; rd = 8; readdata2 = 1;
    push(32'd5, 5'd8, 1'b1, 1'b0, 32'h0, 32'd1);
    run_op("fwd_wb");

    // r0 is never forwarded
    clr();
    rs = 1; rt = 2; rd = 0; readdata1 = 6; readdata2 = 4;
    RegDst = 1; RegWrite = 1;
    push(32'd10, 5'd0, 1'b1, 1'b0, 32'h0, 32'd4);
    run_op("add_r0");
    clr();
    AluOp = ALU_SUB; rs = 0; rt = 2; rd = 4; RegDst = 1; RegWrite = 1;
    readdata1 = 20; readdata2 = 5;
    wb_regwrite = 1; wb_rd = 0; wb_data = 4;
    push(32'd15, 5'd4, 1'b1, 1'b0, 32'h0, 32'd5);
    run_op("no_fwd_r0");

    // Load in EX/MEM must not forward; MEM/WB supplies instead
    clr();
    rs = 1; rt = 6; readdata1 = 32'h1000; sigext = 8;
    AluSrc = 1; MemRead = 1; RegWrite = 1; MemtoReg = 1;
    push(32'h1008, 5'd6, 1'b1, 1'b0, 32'h20, 32'h0);
    run_op("lw_addr");
    clr();
    rs = 6; rt = 6; rd = 10; RegDst = 1; RegWrite = 1;
    readdata1 = 2; readdata2 = 1;
    wb_regwrite = 1; wb_rd = 6; wb_data = 50;
    push(32'd100, 5'd10, 1'b1, 1'b0, 32'h0, 32'd50);
    run_op("no_fwd_load");

    // ALU op table
    for (int i = 0; i < 12; i++) begin
      clr();
      AluOp = tbl[i].op; AluSrc = tbl[i].src;
      rs = 11; rt = 12; rd = 13; RegDst = 1; RegWrite = 1;
      readdata1 = tbl[i].a; readdata2 = tbl[i].b; sigext = tbl[i].sig;
      push(tbl[i].y, 5'd13, 1'b1, 1'b0, tbl[i].sig << 2, tbl[i].b);
      run_op($sformatf("alu%0d", i));
    end

    // BEQ taken / not taken
    clr();
    AluOp = ALU_SUB; branch = 1; rs = 14; rt = 15;
    npc = 32'h100; sigext = 3; readdata1 = 5; readdata2 = 5;
    push(32'h0, 5'd15, 1'b0, 1'b1, 32'h10C, 32'd5);
    run_op("beq_taken");
    readdata2 = 6; jump = 1;
    push(32'hFFFFFFFF, 5'd15, 1'b0, 1'b0, 32'h10C, 32'd6);
    run_op("beq_not");
    chk("jump_pass", 32'(exm_jump), 32'd1);

    mdu_run("mult",  ALU_MULT,  32'hFFFFFFFD, 32'd7,
            32'hFFFFFFFF, 32'hFFFFFFEB);
    mdu_run("multu", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
    mdu_run("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000);
    mdu_run("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
    mdu_run("divu_z", ALU_DIVU, 32'd9, 32'd0,
            32'd9, 32'hFFFFFFFF);

    // Reset in the middle of a multiply (count = 10)
    clr();
    AluOp = ALU_MULT; rs = 16; rt = 17; readdata1 = 5; readdata2 = 5;
    repeat (11) tick();
    chk("pre_rst.stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    clr();
    #1;
    chk("mid_rst.stall", 32'(stall), 32'd0);
    chk("mid_rst.ctl",   32'({exm_pcsrc, exm_jump, exm_MemRead,
                              exm_MemWrite, exm_RegWrite,
                              exm_MemtoReg}), 32'd0);
    chk("mid_rst.res",   exm_alu_result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    AluOp = ALU_MFLO; RegDst = 1; rd = 5'd18; RegWrite = 1;
    push(32'h0, 5'd18, 1'b1, 1'b0, 32'h0, 32'h0);
    run_op("rst_lo");
    AluOp = ALU_MFHI;
    push(32'h0, 5'd18, 1'b1, 1'b0, 32'h0, 32'h0);
    run_op("rst_hi");
    mdu_run("mult_after_rst", ALU_MULT, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
